inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_pkg.sv | 25 ++
 rtl/inst_buffer_if.sv | 55 +++++
 rtl/ib_storage.sv | 37 +++
 rtl/inst_buffer.sv | 105 ++++++++++
 tb/tb_inst_buffer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared front-end types: instruction bus width, buffer entry layout and default depth.
package inst_buffer_pkg;

  localparam int INST_W           = 32;
  localparam int IB_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              is_branch;
  } ib_entry_t;

  localparam int ENTRY_W = $bits(ib_entry_t);

  function automatic ib_entry_t make_entry(input logic [INST_W-1:0] pc,
                                           input logic [INST_W-1:0] inst,
                                           input logic              is_branch);
    ib_entry_t e;
    e.pc        = pc;
    e.inst      = inst;
    e.is_branch = is_branch;
    return e;
  endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-to-decode bundle around the instruction buffer; suffixes are from the buffer's point of view.
interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH_DEFAULT
);

  localparam int CW = $clog2(DEPTH) + 1;

  // write side (fetch)
  logic              valid_1_i;
  logic [INST_W-1:0] inst_1_i;
  logic [INST_W-1:0] pc_1_i;
  logic              is_branch_1_i;
  logic              valid_2_i;
  logic [INST_W-1:0] inst_2_i;
  logic [INST_W-1:0] pc_2_i;
  logic              is_branch_2_i;
  logic              ready_o;
  logic              drop_o;

  // read side (decode)
  logic              pop_1_i;
  logic              pop_2_i;
  logic              valid_1_o;
  logic [INST_W-1:0] inst_1_o;
  logic [INST_W-1:0] pc_1_o;
  logic              is_branch_1_o;
  logic              valid_2_o;
  logic [INST_W-1:0] inst_2_o;
  logic [INST_W-1:0] pc_2_o;
  logic              is_branch_2_o;
  logic [CW-1:0]     count_o;

  modport slave (
    input  valid_1_i, inst_1_i, pc_1_i, is_branch_1_i,
    input  valid_2_i, inst_2_i, pc_2_i, is_branch_2_i,
    output ready_o, drop_o,
    input  pop_1_i, pop_2_i,
    output valid_1_o, inst_1_o, pc_1_o, is_branch_1_o,
    output valid_2_o, inst_2_o, pc_2_o, is_branch_2_o,
    output count_o
  );

  modport master (
    output valid_1_i, inst_1_i, pc_1_i, is_branch_1_i,
    output valid_2_i, inst_2_i, pc_2_i, is_branch_2_i,
    input  ready_o, drop_o,
    output pop_1_i, pop_2_i,
    input  valid_1_o, inst_1_o, pc_1_o, is_branch_1_o,
    input  valid_2_o, inst_2_o, pc_2_o, is_branch_2_o,
    input  count_o
  );

endinterface

// File: rtl/ib_storage.sv
// Two-write / two-read entry array for the instruction buffer; reads are combinational for show-ahead.
module ib_storage
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      we_1_i,
  input  logic [PW-1:0] waddr_1_i,
  input  ib_entry_t wdata_1_i,
  input  logic      we_2_i,
  input  logic [PW-1:0] waddr_2_i,
  input  ib_entry_t wdata_2_i,
  input  logic [PW-1:0] raddr_1_i,
  output ib_entry_t rdata_1_o,
  input  logic [PW-1:0] raddr_2_i,
  output ib_entry_t rdata_2_o
);

  // No reset: stale contents are never visible because the top masks by occupancy.
  ib_entry_t mem_q [DEPTH];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk) begin
    if (we_1_i) begin
      mem_q[waddr_1_i] <= wdata_1_i;
    end
    if (we_2_i) begin
      mem_q[waddr_2_i] <= wdata_2_i;
    end
  end

  assign rdata_1_o = mem_q[raddr_1_i];
  assign rdata_2_o = mem_q[raddr_2_i];

endmodule

// File: rtl/inst_buffer.sv
// Dual-issue circular instruction buffer between fetch and decode: pointers, occupancy, handshake, masking.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  inst_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic      ready;
  logic      wr_1, wr_2;
  logic      rd_valid_1, rd_valid_2;
  logic      pop_1, pop_2;
  logic [1:0] n_wr, n_pop;
  ib_entry_t wdata_1, wdata_2;
  ib_entry_t rdata_1, rdata_2;

  // Space check uses only the registered count; same-cycle pops do not open room.
  assign ready = (count_q <= READY_MAX);

  assign wr_1 = bus.valid_1_i & ready & ~flush;
  assign wr_2 = wr_1 & bus.valid_2_i;

  assign rd_valid_1 = (count_q >= CW'(1));
  assign rd_valid_2 = (count_q >= CW'(2));

  // Slot 2 can only be consumed together with slot 1, keeping pops in order.
  assign pop_1 = bus.pop_1_i & rd_valid_1;
  assign pop_2 = pop_1 & bus.pop_2_i & rd_valid_2;

  assign n_wr  = {1'b0, wr_1} + {1'b0, wr_2};
  assign n_pop = {1'b0, pop_1} + {1'b0, pop_2};

  assign wdata_1 = make_entry(bus.pc_1_i, bus.inst_1_i, bus.is_branch_1_i);
  assign wdata_2 = make_entry(bus.pc_2_i, bus.inst_2_i, bus.is_branch_2_i);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(n_pop);
      tail_d  = tail_q + PW'(n_wr);
      count_d = count_q + CW'(n_wr) - CW'(n_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  ib_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk       (clk),
    .we_1_i    (wr_1),
    .waddr_1_i (tail_q),
    .wdata_1_i (wdata_1),
    .we_2_i    (wr_2),
    .waddr_2_i (tail_q + PW'(1)),
    .wdata_2_i (wdata_2),
    .raddr_1_i (head_q),
    .rdata_1_o (rdata_1),
    .raddr_2_i (head_q + PW'(1)),
    .rdata_2_o (rdata_2)
  );

  assign bus.ready_o = ready;
  assign bus.drop_o  = bus.valid_1_i & ~ready & ~flush & ~rst;
  assign bus.count_o = count_q;

  assign bus.valid_1_o     = rd_valid_1;
  assign bus.inst_1_o      = rd_valid_1 ? rdata_1.inst : '0;
  assign bus.pc_1_o        = rd_valid_1 ? rdata_1.pc : '0;
  assign bus.is_branch_1_o = rd_valid_1 & rdata_1.is_branch;

  assign bus.valid_2_o     = rd_valid_2;
  assign bus.inst_2_o      = rd_valid_2 ? rdata_2.inst : '0;
  assign bus.pc_2_o        = rd_valid_2 ? rdata_2.pc : '0;
  assign bus.is_branch_2_o = rd_valid_2 & rdata_2.is_branch;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed plus randomized bench for inst_buffer, checked against a queue model of the buffer.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  inst_buffer_if #(.DEPTH(DEPTH)) ib_if ();

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (ib_if)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_written = 0;

  ib_entry_t model_q[$];

  logic d_rst, d_fl, d_v1, d_v2, d_p1, d_p2;
  ib_entry_t d_e1, d_e2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ib_entry_t rand_entry();
    ib_entry_t e;
    e.pc        = $urandom;
    e.inst      = $urandom;
    e.is_branch = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic set_idle();
    d_rst = 0; d_fl = 0; d_v1 = 0; d_v2 = 0; d_p1 = 0; d_p2 = 0;
    d_e1 = rand_entry();
    d_e2 = rand_entry();
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    logic exp_ready;
    logic [64:0] exp1, exp2;
    sz = model_q.size();
    exp_ready = ((DEPTH - sz) >= 2);
    exp1 = (sz >= 1) ? model_q[0] : '0;
    exp2 = (sz >= 2) ? model_q[1] : '0;
    chk({tag, ".ready"}, 128'(ib_if.ready_o), 128'(exp_ready));
    chk({tag, ".drop"}, 128'(ib_if.drop_o), 128'(d_v1 && !exp_ready && !d_fl && !d_rst));
    chk({tag, ".count"}, 128'(ib_if.count_o), 128'(sz));
    chk({tag, ".valid1"}, 128'(ib_if.valid_1_o), 128'(sz >= 1));
    chk({tag, ".valid2"}, 128'(ib_if.valid_2_o), 128'(sz >= 2));
    chk({tag, ".entry1"}, 128'({ib_if.pc_1_o, ib_if.inst_1_o, ib_if.is_branch_1_o}), 128'(exp1));
    chk({tag, ".entry2"}, 128'({ib_if.pc_2_o, ib_if.inst_2_o, ib_if.is_branch_2_o}), 128'(exp2));
  endtask

  task automatic model_step();
    int sz;
    bit rdy, p1, p2;
    if (d_rst || d_fl) begin
      model_q.delete();
    end else begin
      sz  = model_q.size();
      rdy = ((DEPTH - sz) >= 2);
      p1  = d_p1 && (sz >= 1);
      p2  = p1 && d_p2 && (sz >= 2);
      if (p1) void'(model_q.pop_front());
      if (p2) void'(model_q.pop_front());
      if (rdy && d_v1) begin model_q.push_back(d_e1); n_written++; end
      if (rdy && d_v1 && d_v2) begin model_q.push_back(d_e2); n_written++; end
    end
  endtask

  // Drive one cycle's inputs, check the combinational view, then advance the clock and the model.
  task automatic cycle(input string tag, input bit do_check);
    rst = d_rst;
    flush = d_fl;
    ib_if.valid_1_i = d_v1;
    ib_if.pc_1_i = d_e1.pc;
    ib_if.inst_1_i = d_e1.inst;
    ib_if.is_branch_1_i = d_e1.is_branch;
    ib_if.valid_2_i = d_v2;
    ib_if.pc_2_i = d_e2.pc;
    ib_if.inst_2_i = d_e2.inst;
    ib_if.is_branch_2_i = d_e2.is_branch;
    ib_if.pop_1_i = d_p1;
    ib_if.pop_2_i = d_p2;
    #1;
    if (do_check) check_outputs(tag);
    $display("cyc %s: rst=%0b fl=%0b v1=%0b v2=%0b p1=%0b p2=%0b count=%0d", tag, d_rst, d_fl,
             d_v1, d_v2, d_p1, d_p2, ib_if.count_o);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    d_rst = 1;
    cycle("reset", 1);
    set_idle();
  endtask

  task automatic write_n(input string tag, input int n2, input int n1);
    for (int i = 0; i < n2; i++) begin
      set_idle(); d_v1 = 1; d_v2 = 1;
      cycle(tag, 1);
    end
    for (int i = 0; i < n1; i++) begin
      set_idle(); d_v1 = 1;
      cycle(tag, 1);
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    d_rst = 1;
    cycle("por", 0);
    set_idle();
    cycle("after_reset", 1);

    // Two writes, visible the following cycle.
    d_v1 = 1; d_v2 = 1;
    d_e1.pc = 32'h1c00_0000;
    d_e2.pc = 32'h1c00_0004;
    cycle("w2", 1);
    set_idle();
    cycle("w2_read", 1);

    // Fill to 15 then attempt writes.
    do_reset();
    write_n("fill15", 7, 1);
    d_v1 = 1; d_v2 = 1;
    cycle("drop15", 1);
    cycle("drop15b", 1);

    // Fill to 16 then attempt writes.
    do_reset();
    write_n("fill16", 8, 0);
    d_v1 = 1;
    cycle("drop16", 1);
    set_idle();
    cycle("full16", 1);

    // count=1, write two and pop two: only one pop takes effect.
    do_reset();
    write_n("one", 0, 1);
    d_v1 = 1; d_v2 = 1; d_p1 = 1; d_p2 = 1;
    cycle("wp", 1);
    set_idle();
    cycle("wp_after", 1);
    d_p1 = 0; d_p2 = 1;
    cycle("pop2_alone", 1);
    d_p1 = 1; d_p2 = 1;
    cycle("drain", 1);
    set_idle();
    cycle("drained", 1);

    // Randomized streaming through pointer wraps.
    do_reset();
    n_written = 0;
    for (int c = 0; c < 400 && (n_written < 48 || c < 80); c++) begin
      set_idle();
      d_v1 = ($urandom_range(0, 3) != 0);
      d_v2 = 1'($urandom_range(0, 1));
      d_p1 = 1'($urandom_range(0, 1));
      d_p2 = 1'($urandom_range(0, 1));
      cycle("rand", 1);
    end
    set_idle();
    for (int c = 0; c < 12; c++) begin
      d_p1 = 1; d_p2 = 1;
      cycle("rand_drain", 1);
    end
    chk("rand.min_written", 128'(n_written >= 40), 128'(1));

    // Flush at count 7 overrides writes and pops.
    do_reset();
    write_n("pre_flush", 3, 1);
    d_fl = 1; d_v1 = 1; d_v2 = 1; d_p1 = 1; d_p2 = 1;
    cycle("flush", 1);
    set_idle();
    cycle("after_flush", 1);

    // rst and flush together at count 5, then valid_2 alone.
    write_n("pre_rst", 2, 1);
    d_rst = 1; d_fl = 1; d_v1 = 1; d_p1 = 1;
    cycle("rst_flush", 1);
    set_idle();
    cycle("after_rst_flush", 1);
    d_v2 = 1;
    cycle("v2_alone", 1);
    set_idle();
    cycle("after_v2_alone", 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
